// File: rtl/pwm_strobe_pkg.sv
// Shared types, widths and counter helpers for the PWM strobe generator.
package pwm_strobe_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] duty;
  } cfg_t;

  // Duty is clamped to the period at capture so the run logic never sees duty>period.
  function automatic cfg_t make_cfg(input logic [CNT_W_DEF-1:0] period,
                                    input logic [CNT_W_DEF-1:0] duty);
    cfg_t c;
    c.period = period;
    c.duty   = (duty > period) ? period : duty;
    return c;
  endfunction

  // Increment-then-compare avoids underflow of period-1 and overflow at the top count.
  function automatic logic [CNT_W_DEF-1:0] wrap_inc(input logic [CNT_W_DEF-1:0] cnt,
                                                    input logic [CNT_W_DEF-1:0] period);
    logic [CNT_W_DEF-1:0] inc;
    inc = cnt + 1'b1;
    return (inc >= period) ? '0 : inc;
  endfunction

endpackage

// File: rtl/pwm_strobe_gen.sv
// Set/reset strobe generator for an SR latch forming a PWM output; strobes lag the counter by one cycle.
// Period/duty commands are double-buffered (cfg_ready low while the shadow is full); KILL_EN adds a level kill input.
module pwm_strobe_gen
  import pwm_strobe_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned INIT_PERIOD = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
`ifdef KILL_EN
  input  logic             kill,
`endif
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             set_o,
  output logic             reset_o,
  output logic             q_track,
  output logic             period_start
);

  localparam logic [CNT_W_DEF-1:0] INIT_P = CNT_W_DEF'(INIT_PERIOD);

  state_t               state_q, state_d;
  logic [CNT_W_DEF-1:0] cnt_q, cnt_d;
  cfg_t                 act_q, act_d;
  cfg_t                 shd_q, shd_d;
  logic                 shd_full_q, shd_full_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 q_track_q, q_track_d;
  logic                 set_q, set_d;
  logic                 reset_q, reset_d;
  logic                 ps_q, ps_d;

  logic                 stop_req;
  logic                 start_ok;
  logic                 accept;
  cfg_t                 cfg_in;
  cfg_t                 eff;

`ifdef KILL_EN
  // Lock survives the kill until enable is seen low, so restart needs a fresh enable edge.
  logic kill_lock_q, kill_lock_d;

  always_comb begin
    kill_lock_d = kill | (kill_lock_q & enable);
    stop_req    = ~enable | kill;
    start_ok    = enable & ~kill & ~kill_lock_q;
  end

  always_ff @(posedge clk) begin
    if (reset) kill_lock_q <= 1'b0;
    else       kill_lock_q <= kill_lock_d;
  end
`else
  always_comb begin
    stop_req = ~enable;
    start_ok = enable;
  end
`endif

  always_comb begin
    accept = cfg_valid & cfg_ready_q;
    cfg_in = make_cfg(cfg_period, cfg_duty);
    eff    = shd_full_q ? shd_q : act_q;

    state_d    = state_q;
    cnt_d      = cnt_q;
    act_d      = act_q;
    shd_d      = shd_q;
    shd_full_d = shd_full_q;
    q_track_d  = q_track_q;
    set_d      = 1'b0;
    reset_d    = 1'b0;
    ps_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (q_track_q) begin
          reset_d   = 1'b1;
          q_track_d = 1'b0;
        end
        if (accept) act_d = cfg_in;
        if (start_ok && (act_q.period != '0)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end

      RUN: begin
        if (accept) begin
          shd_d      = cfg_in;
          shd_full_d = 1'b1;
        end
        if (stop_req) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (q_track_q) begin
            reset_d   = 1'b1;
            q_track_d = 1'b0;
          end
        end else if (cnt_q == '0) begin
          act_d = eff;
          if (shd_full_q) shd_full_d = 1'b0;
          if (eff.period == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (q_track_q) begin
              reset_d   = 1'b1;
              q_track_d = 1'b0;
            end
          end else begin
            ps_d  = 1'b1;
            cnt_d = wrap_inc(cnt_q, eff.period);
            if (eff.duty == '0) begin
              if (q_track_q) begin
                reset_d   = 1'b1;
                q_track_d = 1'b0;
              end
            end else if (!q_track_q) begin
              set_d     = 1'b1;
              q_track_d = 1'b1;
            end
          end
        end else begin
          cnt_d = wrap_inc(cnt_q, act_q.period);
          if ((cnt_q == act_q.duty) && (act_q.duty < act_q.period) && q_track_q) begin
            reset_d   = 1'b1;
            q_track_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    cfg_ready_d = ~shd_full_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      act_q       <= '{period: INIT_P, duty: '0};
      shd_q       <= '0;
      shd_full_q  <= 1'b0;
      cfg_ready_q <= 1'b1;
      q_track_q   <= 1'b0;
      set_q       <= 1'b0;
      reset_q     <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      shd_q       <= shd_d;
      shd_full_q  <= shd_full_d;
      cfg_ready_q <= cfg_ready_d;
      q_track_q   <= q_track_d;
      set_q       <= set_d;
      reset_q     <= reset_d;
      ps_q        <= ps_d;
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign set_o        = set_q;
  assign reset_o      = reset_q;
  assign q_track      = q_track_q;
  assign period_start = ps_q;

endmodule
